// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, ALU and PC-source
// codes, trap causes, FSM state encoding and the opcode-class struct.
package cpu_pkg;

    localparam logic [6:0] OP_ADD  = 7'd0;
    localparam logic [6:0] OP_SUB  = 7'd1;
    localparam logic [6:0] OP_MUL  = 7'd2;
    localparam logic [6:0] OP_LDB  = 7'd16;
    localparam logic [6:0] OP_LDW  = 7'd17;
    localparam logic [6:0] OP_STB  = 7'd18;
    localparam logic [6:0] OP_STW  = 7'd19;
    localparam logic [6:0] OP_BEQ  = 7'd48;
    localparam logic [6:0] OP_JUMP = 7'd49;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic legal;
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_byte;
        logic is_branch;
        logic is_jump;
    } op_class_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier: maps a 7-bit opcode onto the instruction
// class flags the sequencer steers on.
module ctrl_opdecode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
                cls.legal  = 1'b1;
                cls.is_alu = 1'b1;
            end
            OP_LDB: begin
                cls.legal   = 1'b1;
                cls.is_load = 1'b1;
                cls.is_byte = 1'b1;
            end
            OP_LDW: begin
                cls.legal   = 1'b1;
                cls.is_load = 1'b1;
            end
            OP_STB: begin
                cls.legal    = 1'b1;
                cls.is_store = 1'b1;
                cls.is_byte  = 1'b1;
            end
            OP_STW: begin
                cls.legal    = 1'b1;
                cls.is_store = 1'b1;
            end
            OP_BEQ: begin
                cls.legal     = 1'b1;
                cls.is_branch = 1'b1;
            end
            OP_JUMP: begin
                cls.legal   = 1'b1;
                cls.is_jump = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready timeout and
// illegal-opcode trap. Define MUL_STALL_EN to hold MUL in EXEC for MUL_LATENCY cycles.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [3:0] alu_ctrl,
    output logic       dmem_rd_b,
    output logic       dmem_rd_w,
    output logic       dmem_wr_b,
    output logic       dmem_wr_w,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       trap,
    output logic [1:0] trap_cause,
    output state_t     dbg_state
);

    if (MEM_TIMEOUT < 1 || MUL_LATENCY < 1) begin : g_bad_param
        $error("multicycle_ctrl: MEM_TIMEOUT and MUL_LATENCY must be >= 1");
    end

    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] TO_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [6:0]       dec_in;
    op_class_t        cls;

`ifdef MUL_STALL_EN
    localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_LATENCY - 1);
    logic [MCW-1:0]   mul_q, mul_d;
`endif

    // DECODE classifies the live opcode; later states use the latched copy.
    assign dec_in = (state_q == ST_DECODE) ? opcode : op_q;

    ctrl_opdecode u_opdecode (
        .opcode (dec_in),
        .cls    (cls)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cause_d = cause_q;
        wait_d  = '0;
`ifdef MUL_STALL_EN
        mul_d   = mul_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_q == TO_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (cls.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (cls.is_alu) begin
`ifdef MUL_STALL_EN
                    if (op_q == OP_MUL && mul_q != MUL_LAST) begin
                        mul_d = mul_q + 1'b1;
                    end else begin
                        mul_d   = '0;
                        state_d = ST_WB;
                    end
`else
                    state_d = ST_WB;
`endif
                end else if (cls.is_load || cls.is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                // Ready wins over a timeout expiring in the same cycle.
                if (dmem_ready) begin
                    state_d = cls.is_load ? ST_WB : ST_FETCH;
                end else if (wait_q == TO_LAST) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cause_q <= TRAP_NONE;
`ifdef MUL_STALL_EN
            mul_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
`ifdef MUL_STALL_EN
            mul_q   <= mul_d;
`endif
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PC4;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_ADD;
        dmem_rd_b  = 1'b0;
        dmem_rd_w  = 1'b0;
        dmem_wr_b  = 1'b0;
        dmem_wr_w  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        trap       = 1'b0;
        trap_cause = TRAP_NONE;
        if (!rst) begin
            trap_cause = cause_q;
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cls.is_alu) begin
                        alu_ctrl = op_q[3:0];
                    end else if (cls.is_load || cls.is_store) begin
                        alu_src = 1'b1;
                    end else if (cls.is_branch) begin
                        alu_ctrl = ALU_SUB;
                        pc_write = zero;
                        pc_src   = PC_SRC_BRANCH;
                    end else if (cls.is_jump) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                    end
                end
                ST_MEM: begin
                    alu_src   = 1'b1;
                    dmem_rd_b = cls.is_load  &  cls.is_byte;
                    dmem_rd_w = cls.is_load  & ~cls.is_byte;
                    dmem_wr_b = cls.is_store &  cls.is_byte;
                    dmem_wr_w = cls.is_store & ~cls.is_byte;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = cls.is_load;
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomised bench for multicycle_ctrl: per-cycle stimulus and
// expected output vectors are queued together, then applied and compared.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    localparam int W  = 22;
    localparam int SW = 11;
    localparam int MEM_TO = 16;
`ifdef MUL_STALL_EN
    localparam int MUL_EXEC = 4;
`else
    localparam int MUL_EXEC = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero, imem_ready, dmem_ready;
    logic       imem_req, ir_write, pc_write, alu_src;
    logic [1:0] pc_src, trap_cause;
    logic [3:0] alu_ctrl;
    logic       dmem_rd_b, dmem_rd_w, dmem_wr_b, dmem_wr_w;
    logic       reg_write, mem_to_reg, trap;
    state_t     dbg_state;

    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] stim_q[$];
    string         tag_q[$];
    int            vectors = 0;
    int            miscompares = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TO), .MUL_LATENCY(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .dmem_rd_b  (dmem_rd_b),
        .dmem_rd_w  (dmem_rd_w),
        .dmem_wr_b  (dmem_wr_b),
        .dmem_wr_w  (dmem_wr_w),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .trap_cause (trap_cause),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector helpers ----------------
    // Expected layout: {state, imem_req, ir_write, pc_write, pc_src, alu_src, alu_ctrl,
    //                   rd_b, rd_w, wr_b, wr_w, reg_write, mem_to_reg, trap, trap_cause}
    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [2:0] f3,
                                        input logic [1:0] pcs, input logic asrc,
                                        input logic [3:0] actl, input logic [3:0] m4,
                                        input logic [1:0] wb2, input logic tr,
                                        input logic [1:0] cause);
        return {st, f3, pcs, asrc, actl, m4, wb2, tr, cause};
    endfunction

    function automatic logic [SW-1:0] mkin(input logic r, input logic ir, input logic dr,
                                           input logic z, input logic [6:0] op);
        return {r, ir, dr, z, op};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic push(input logic [SW-1:0] s, input logic [W-1:0] e, input string t);
        stim_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // ---------------- driver tasks (queue stimulus + expectations) ----------------
    task automatic p_fetch(input int iw);
        for (int i = 0; i < iw; i++)
            push(mkin(1'b0, 1'b0, rb(), rb(), ro()),
                 mk(ST_FETCH, 3'b100, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "fetch_wait");
        push(mkin(1'b0, 1'b1, rb(), rb(), ro()),
             mk(ST_FETCH, 3'b111, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "fetch_ready");
    endtask

    task automatic p_decode(input logic [6:0] op);
        push(mkin(1'b0, rb(), rb(), rb(), op),
             mk(ST_DECODE, 3'b000, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "decode");
    endtask

    task automatic p_wb(input logic m);
        push(mkin(1'b0, rb(), rb(), rb(), ro()),
             mk(ST_WB, 3'b000, 2'd0, 1'b0, 4'd0, 4'b0000, {1'b1, m}, 1'b0, 2'd0), "wb");
    endtask

    task automatic p_mem(input logic [3:0] m4, input int dw, input logic ready_end);
        for (int i = 0; i < dw; i++)
            push(mkin(1'b0, rb(), 1'b0, rb(), ro()),
                 mk(ST_MEM, 3'b000, 2'd0, 1'b1, 4'd0, m4, 2'b00, 1'b0, 2'd0), "mem_wait");
        if (ready_end)
            push(mkin(1'b0, rb(), 1'b1, rb(), ro()),
                 mk(ST_MEM, 3'b000, 2'd0, 1'b1, 4'd0, m4, 2'b00, 1'b0, 2'd0), "mem_ready");
    endtask

    task automatic p_trap(input logic [1:0] cause, input int n);
        for (int i = 0; i < n; i++)
            push(mkin(1'b0, rb(), rb(), rb(), ro()),
                 mk(ST_TRAP, 3'b000, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b1, cause), "trap");
    endtask

    task automatic p_reset(input logic [2:0] prev, input int n);
        push(mkin(1'b1, rb(), rb(), rb(), ro()),
             mk(prev, 3'b000, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "reset_first");
        for (int i = 1; i < n; i++)
            push(mkin(1'b1, rb(), rb(), rb(), ro()),
                 mk(ST_FETCH, 3'b000, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "reset_hold");
    endtask

    task automatic p_exec_mem();
        push(mkin(1'b0, rb(), rb(), rb(), ro()),
             mk(ST_EXEC, 3'b000, 2'd0, 1'b1, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "exec_mem");
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int iw, input int dw);
        p_fetch(iw);
        p_decode(op);
        if (op == OP_ADD || op == OP_SUB || op == OP_MUL) begin
            logic [3:0] code;
            int n;
            code = (op == OP_ADD) ? 4'd0 : (op == OP_SUB) ? 4'd1 : 4'd2;
            n = (op == OP_MUL) ? MUL_EXEC : 1;
            for (int i = 0; i < n; i++)
                push(mkin(1'b0, rb(), rb(), rb(), ro()),
                     mk(ST_EXEC, 3'b000, 2'd0, 1'b0, code, 4'b0000, 2'b00, 1'b0, 2'd0), "exec_alu");
            p_wb(1'b0);
        end else if (op == OP_LDB || op == OP_LDW || op == OP_STB || op == OP_STW) begin
            logic [3:0] m4;
            m4 = (op == OP_LDB) ? 4'b1000 : (op == OP_LDW) ? 4'b0100 :
                 (op == OP_STB) ? 4'b0010 : 4'b0001;
            p_exec_mem();
            p_mem(m4, dw, 1'b1);
            if (op == OP_LDB || op == OP_LDW) p_wb(1'b1);
        end else if (op == OP_BEQ) begin
            push(mkin(1'b0, rb(), rb(), z, ro()),
                 mk(ST_EXEC, {2'b00, z}, 2'd1, 1'b0, 4'd1, 4'b0000, 2'b00, 1'b0, 2'd0), "exec_beq");
        end else begin
            push(mkin(1'b0, rb(), rb(), rb(), ro()),
                 mk(ST_EXEC, 3'b001, 2'd2, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "exec_jump");
        end
    endtask

    // ---------------- scoreboard: apply and compare ----------------
    task automatic drain();
        logic [SW-1:0] s;
        logic [W-1:0]  e, obs;
        string         t;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            {rst, imem_ready, dmem_ready, zero, opcode} = s;
            @(negedge clk);
            obs = {dbg_state, imem_req, ir_write, pc_write, pc_src, alu_src, alu_ctrl,
                   dmem_rd_b, dmem_rd_w, dmem_wr_b, dmem_wr_w, reg_write, mem_to_reg,
                   trap, trap_cause};
            vectors++;
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s obs=%h exp=%h", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [6:0] legal_ops [9];

    initial begin
        legal_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_BEQ, OP_JUMP};
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;

        p_reset(ST_FETCH, 2);                    // outputs forced low in reset
        run_instr(OP_ADD, 1'b0, 0, 0);
        run_instr(OP_SUB, 1'b0, 0, 0);
        run_instr(OP_MUL, 1'b0, 0, 0);
        run_instr(OP_LDB, 1'b0, 0, 3);           // dmem_rd_b held 4 cycles
        run_instr(OP_LDW, 1'b0, 2, 0);
        run_instr(OP_STW, 1'b0, 0, 0);
        run_instr(OP_STB, 1'b0, 0, 1);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_JUMP, 1'b0, 0, 0);

        // ready on the last allowed cycle of each access still succeeds
        run_instr(OP_STB, 1'b0, MEM_TO - 1, MEM_TO - 1);
        run_instr(OP_LDW, 1'b0, 0, MEM_TO - 1);

        // illegal opcode traps and holds until reset
        p_fetch(0); p_decode(7'd5); p_trap(2'd1, 4); p_reset(ST_TRAP, 2);
        p_fetch(0); p_decode(7'd127); p_trap(2'd1, 2); p_reset(ST_TRAP, 1);

        // data memory never ready: 16 MEM cycles then bus-timeout trap
        p_fetch(0); p_decode(OP_LDW); p_exec_mem(); p_mem(4'b0100, MEM_TO, 1'b0);
        p_trap(2'd2, 3); p_reset(ST_TRAP, 1);

        // instruction memory never ready: 16 FETCH cycles then bus-timeout trap
        for (int i = 0; i < MEM_TO; i++)
            push(mkin(1'b0, 1'b0, rb(), rb(), ro()),
                 mk(ST_FETCH, 3'b100, 2'd0, 1'b0, 4'd0, 4'b0000, 2'b00, 1'b0, 2'd0), "fetch_wait");
        p_trap(2'd2, 2); p_reset(ST_TRAP, 2);

        // reset in the middle of a data access aborts it
        p_fetch(0); p_decode(OP_STW); p_exec_mem(); p_mem(4'b0001, 2, 1'b0);
        p_reset(ST_MEM, 2);
        run_instr(OP_ADD, 1'b0, 0, 0);

        // randomised instruction stream
        for (int i = 0; i < 40; i++)
            run_instr(legal_ops[$urandom_range(0, 8)], rb(),
                      $urandom_range(0, 3), $urandom_range(0, 4));

        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
